// File: rtl/rgb_matrix_pkg.sv
// rtl/rgb_matrix_pkg.sv - shared types, defaults and helpers for the RGB matrix scan driver
package rgb_matrix_pkg;

    localparam int COLS_DEFAULT        = 32;
    localparam int ROW_ADDR_W_DEFAULT  = 4;
    localparam int BPC_DEFAULT         = 4;
    localparam int BASE_CYCLES_DEFAULT = 8;

    // Colour field order inside one frame-buffer word
    localparam int R0         = 0;
    localparam int G0         = 1;
    localparam int B0         = 2;
    localparam int R1         = 3;
    localparam int G1         = 4;
    localparam int B1         = 5;
    localparam int NUM_FIELDS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY,
        ST_BLANK
    } scan_state_e;

    function automatic int unsigned bcm_cycles(input int unsigned base, input int unsigned plane);
        return base << plane;
    endfunction

endpackage

// File: rtl/rgb_matrix_bcm_timer.sv
// rtl/rgb_matrix_bcm_timer.sv - binary-weighted display-time counter for one bit-plane
module rgb_matrix_bcm_timer
    import rgb_matrix_pkg::*;
#(
    parameter int  BPC         = BPC_DEFAULT,
    parameter int  BASE_CYCLES = BASE_CYCLES_DEFAULT,
    localparam int PLANE_W     = (BPC > 1) ? $clog2(BPC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [PLANE_W-1:0] plane_i,
    output logic               done_o
);

    localparam int MAX_CYCLES = BASE_CYCLES << (BPC - 1);
    localparam int DCNT_W     = $clog2(MAX_CYCLES + 1);

    logic [DCNT_W-1:0] dcount_q, dcount_d;
    logic              active_q, active_d;

    // Counts down from length-1 so done_o marks the last display cycle
    always_comb begin
        dcount_d = dcount_q;
        active_d = active_q;
        if (start_i) begin
            dcount_d = DCNT_W'(bcm_cycles(BASE_CYCLES, 32'(plane_i)) - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (dcount_q == '0) begin
                active_d = 1'b0;
            end else begin
                dcount_d = dcount_q - DCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcount_q <= '0;
            active_q <= 1'b0;
        end else begin
            dcount_q <= dcount_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (dcount_q == '0);

endmodule

// File: rtl/rgb_matrix_scan.sv
// rtl/rgb_matrix_scan.sv - HUB75 scan driver: shift, latch and BCM-display one bit-plane per row pass
module rgb_matrix_scan
    import rgb_matrix_pkg::*;
#(
    parameter int  COLS        = COLS_DEFAULT,
    parameter int  ROW_ADDR_W  = ROW_ADDR_W_DEFAULT,
    parameter int  BPC         = BPC_DEFAULT,
    parameter int  BASE_CYCLES = BASE_CYCLES_DEFAULT,
    localparam int COL_W       = $clog2(COLS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    output logic [ROW_ADDR_W+COL_W-1:0] fb_addr,
    input  logic [NUM_FIELDS*BPC-1:0]   fb_data,
    output logic                        r0,
    output logic                        g0,
    output logic                        b0,
    output logic                        r1,
    output logic                        g1,
    output logic                        b1,
    output logic                        sclk,
    output logic                        lat,
    output logic                        oe_n,
    output logic [ROW_ADDR_W-1:0]       row_addr,
    output logic                        frame_start
);

    localparam int                 PLANE_W    = (BPC > 1) ? $clog2(BPC) : 1;
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BPC - 1);

    scan_state_e                   state_q, state_d;
    logic [ROW_ADDR_W-1:0]         row_q, row_d;
    logic [PLANE_W-1:0]            plane_q, plane_d;
    logic [COL_W-1:0]              col_q, col_d;
    logic                          phase_q, phase_d;
    logic [ROW_ADDR_W+COL_W-1:0]   fb_addr_q, fb_addr_d;
    logic [NUM_FIELDS-1:0]         pix_q, pix_d;
    logic                          sclk_q, sclk_d;
    logic                          lat_q, lat_d;
    logic                          oe_n_q, oe_n_d;
    logic [ROW_ADDR_W-1:0]         row_addr_q, row_addr_d;
    logic                          frame_start_q, frame_start_d;

    logic [NUM_FIELDS-1:0]         plane_bits;
    logic [NUM_FIELDS-1:0]         pix_out;
    logic [ROW_ADDR_W-1:0]         next_row;
    logic [PLANE_W-1:0]            next_plane;
    logic                          timer_start;
    logic                          timer_done;

    always_comb begin
        plane_bits = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            plane_bits[k] = fb_data[k*BPC + int'(plane_q)];
        end
    end

    always_comb begin
        next_row   = row_q;
        next_plane = plane_q + PLANE_W'(1);
        if (plane_q == LAST_PLANE) begin
            next_plane = '0;
            next_row   = row_q + ROW_ADDR_W'(1);
        end
    end

    assign timer_start = (state_q == ST_LATCH);

    rgb_matrix_bcm_timer #(
        .BPC         (BPC),
        .BASE_CYCLES (BASE_CYCLES)
    ) u_bcm_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (timer_start),
        .plane_i (plane_q),
        .done_o  (timer_done)
    );

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        plane_d       = plane_q;
        col_d         = col_q;
        phase_d       = phase_q;
        fb_addr_d     = fb_addr_q;
        pix_d         = pix_q;
        frame_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d       = ST_PREFETCH;
                    fb_addr_d     = {row_q, {COL_W{1'b0}}};
                    frame_start_d = (row_q == '0) && (plane_q == '0);
                end
            end
            ST_PREFETCH: begin
                state_d = ST_SHIFT;
                col_d   = '0;
                phase_d = 1'b0;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    // Address for col+1 goes out now so its data lands in the next phase 0
                    phase_d   = 1'b1;
                    pix_d     = plane_bits;
                    fb_addr_d = {row_q, col_q + COL_W'(1)};
                end else begin
                    phase_d = 1'b0;
                    if (col_q == LAST_COL) begin
                        state_d = ST_LATCH;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (timer_done) begin
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                row_d   = next_row;
                plane_d = next_plane;
                if (enable) begin
                    state_d       = ST_PREFETCH;
                    fb_addr_d     = {next_row, {COL_W{1'b0}}};
                    frame_start_d = (next_row == '0) && (next_plane == '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Panel controls are registered from the next state so the pins never glitch
        sclk_d     = (state_d == ST_SHIFT) && phase_d;
        lat_d      = (state_d == ST_LATCH);
        oe_n_d     = (state_d != ST_DISPLAY);
        row_addr_d = (state_d == ST_LATCH) ? row_q : row_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            plane_q       <= '0;
            col_q         <= '0;
            phase_q       <= 1'b0;
            fb_addr_q     <= '0;
            pix_q         <= '0;
            sclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            oe_n_q        <= 1'b1;
            row_addr_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            plane_q       <= plane_d;
            col_q         <= col_d;
            phase_q       <= phase_d;
            fb_addr_q     <= fb_addr_d;
            pix_q         <= pix_d;
            sclk_q        <= sclk_d;
            lat_q         <= lat_d;
            oe_n_q        <= oe_n_d;
            row_addr_q    <= row_addr_d;
            frame_start_q <= frame_start_d;
        end
    end

    // In phase 0 the RAM word is passed straight through so it has settled before sclk rises
    assign pix_out = (state_q == ST_SHIFT && !phase_q) ? plane_bits : pix_q;

    assign r0          = pix_out[R0];
    assign g0          = pix_out[G0];
    assign b0          = pix_out[B0];
    assign r1          = pix_out[R1];
    assign g1          = pix_out[G1];
    assign b1          = pix_out[B1];
    assign fb_addr     = fb_addr_q;
    assign sclk        = sclk_q;
    assign lat         = lat_q;
    assign oe_n        = oe_n_q;
    assign row_addr    = row_addr_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb_matrix_scan.sv
// tb/tb_rgb_matrix_scan.sv - self-checking bench for rgb_matrix_scan
module tb_rgb_matrix_scan;

    localparam int COLS  = 4;
    localparam int RAW   = 2;
    localparam int BPC   = 2;
    localparam int BASE  = 3;
    localparam int COL_W = 2;
    localparam int AW    = RAW + COL_W;
    localparam int NROWS = 1 << RAW;

    logic clk = 1'b0;
    logic rst_n, enable, enable_w;

    logic [AW-1:0]      fb_addr;
    logic [6*BPC-1:0]   fb_data;
    logic r0, g0, b0, r1, g1, b1, sclk, lat, oe_n, frame_start;
    logic [RAW-1:0]     row_addr;

    logic [1:0]         fb_addr_w;
    logic [23:0]        fb_data_w;
    logic r0_w, g0_w, b0_w, r1_w, g1_w, b1_w, sclk_w, lat_w, oe_n_w, frame_start_w;
    logic [0:0]         row_addr_w;

    always #5 clk = ~clk;

    rgb_matrix_scan #(.COLS(COLS), .ROW_ADDR_W(RAW), .BPC(BPC), .BASE_CYCLES(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb_addr(fb_addr), .fb_data(fb_data),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .sclk(sclk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr), .frame_start(frame_start)
    );

    rgb_matrix_scan #(.COLS(2), .ROW_ADDR_W(1), .BPC(4), .BASE_CYCLES(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(enable_w), .fb_addr(fb_addr_w), .fb_data(fb_data_w),
        .r0(r0_w), .g0(g0_w), .b0(b0_w), .r1(r1_w), .g1(g1_w), .b1(b1_w),
        .sclk(sclk_w), .lat(lat_w), .oe_n(oe_n_w), .row_addr(row_addr_w), .frame_start(frame_start_w)
    );

    // Frame buffer: registered read, data one cycle after the address
    logic [6*BPC-1:0] mem [NROWS][COLS];
    always @(posedge clk) fb_data <= mem[fb_addr[AW-1:COL_W]][fb_addr[COL_W-1:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected panel activity, one entry per clock cycle
    typedef struct packed {
        logic           sclk;
        logic           lat;
        logic           oe_n;
        logic           fs;
        logic           chk_col;
        logic [5:0]     col;
        logic           chk_addr;
        logic [AW-1:0]  addr;
        logic           show_row;
        logic [RAW-1:0] row;
    } exp_t;

    exp_t q[$];
    exp_t cur_e;
    int   m_row = 0, m_plane = 0, shown_row = 0;
    logic en_s = 1'b0;

    function automatic logic [5:0] pix_bits(input int r, input int c, input int p);
        logic [6*BPC-1:0] w;
        logic [5:0]       b;
        w = mem[r][c];
        for (int k = 0; k < 6; k++) b[k] = w[k*BPC + p];
        return b;
    endfunction

    task automatic push_plane(input int r, input int p);
        exp_t e;
        e = '0; e.oe_n = 1'b1; e.fs = (r == 0 && p == 0);
        e.chk_addr = 1'b1; e.addr = AW'(r * COLS);
        q.push_back(e);
        for (int c = 0; c < COLS; c++) begin
            e = '0; e.oe_n = 1'b1; e.chk_addr = 1'b1; e.addr = AW'(r * COLS + c);
            q.push_back(e);
            e = '0; e.oe_n = 1'b1; e.sclk = 1'b1; e.chk_col = 1'b1; e.col = pix_bits(r, c, p);
            e.chk_addr = 1'b1; e.addr = AW'(r * COLS + (c + 1) % COLS);
            q.push_back(e);
        end
        e = '0; e.oe_n = 1'b1; e.lat = 1'b1; e.show_row = 1'b1; e.row = RAW'(r);
        q.push_back(e);
        for (int i = 0; i < (BASE << p); i++) begin
            e = '0; e.oe_n = 1'b0;
            q.push_back(e);
        end
        e = '0; e.oe_n = 1'b1;
        q.push_back(e);
    endtask

    always @(posedge clk) en_s <= rst_n && enable;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_row = 0; m_plane = 0; shown_row = 0;
        end else begin
            if (q.size() == 0 && en_s) begin
                push_plane(m_row, m_plane);
                if (m_plane == BPC - 1) begin
                    m_plane = 0;
                    m_row   = (m_row + 1) % NROWS;
                end else begin
                    m_plane++;
                end
            end
            if (q.size() == 0) begin
                cur_e = '0; cur_e.oe_n = 1'b1;
            end else begin
                cur_e = q.pop_front();
            end
            if (cur_e.show_row) shown_row = cur_e.row;
            chk("sclk", 32'(sclk), 32'(cur_e.sclk));
            chk("lat", 32'(lat), 32'(cur_e.lat));
            chk("oe_n", 32'(oe_n), 32'(cur_e.oe_n));
            chk("frame_start", 32'(frame_start), 32'(cur_e.fs));
            chk("row_addr", 32'(row_addr), 32'(shown_row));
            if (cur_e.chk_col) chk("colour", 32'({b1, g1, r1, b0, g0, r0}), 32'(cur_e.col));
            if (cur_e.chk_addr) chk("fb_addr", 32'(fb_addr), 32'(cur_e.addr));
        end
    end

    // Event log for the hand-computed expectations
    int oe_runs[$], lat_rows[$], sclk_per[$], r0_log[$], w_runs[$];
    int fs_count = 0, fs_addr = -1, run = 0, wrun = 0, sclk_cnt = 0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0; wrun = 0; sclk_cnt = 0; prev_sclk = 1'b0;
        end else begin
            if (oe_n == 1'b0) run++;
            else if (run != 0) begin oe_runs.push_back(run); run = 0; end
            if (oe_n_w == 1'b0) wrun++;
            else if (wrun != 0) begin w_runs.push_back(wrun); wrun = 0; end
            if (sclk && !prev_sclk) begin sclk_cnt++; r0_log.push_back(int'(r0)); end
            prev_sclk = sclk;
            if (lat) begin lat_rows.push_back(int'(row_addr)); sclk_per.push_back(sclk_cnt); sclk_cnt = 0; end
            if (frame_start) begin fs_count++; fs_addr = int'(fb_addr); end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_lat(input int n, input int budget);
        int i = 0;
        while (lat_rows.size() < n && i < budget) begin step(); i++; end
        chk("wait_lat_timeout", 32'(lat_rows.size() >= n), 32'd1);
    endtask

    task automatic wait_runs(input int n, input int budget);
        int i = 0;
        while (oe_runs.size() < n && i < budget) begin step(); i++; end
        chk("wait_oe_timeout", 32'(oe_runs.size() >= n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_rows[9];
        int n0, fsb, i, base;
        exp_rows = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mem[r][c] = '0;
                mem[r][c][0 +: BPC]  = (c % 2 == 0) ? 2'b01 : 2'b10;
                mem[r][c][2 +: BPC]  = 2'(c);
                mem[r][c][10 +: BPC] = 2'(r);
            end
        end
        fb_data_w = '0;
        enable = 1'b0; enable_w = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        step();
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_lat", 32'(lat), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_row_addr", 32'(row_addr), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_colour", 32'({b1, g1, r1, b0, g0, r0}), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) step();
        #1 enable = 1'b1; enable_w = 1'b1;

        // Full frame plus the first plane of the next one
        wait_lat(9, 400);
        for (int k = 0; k < 9; k++) chk("lat_row_seq", 32'(lat_rows[k]), 32'(exp_rows[k]));
        chk("r0_p0_c0", 32'(r0_log[0]), 32'd1);
        chk("r0_p0_c1", 32'(r0_log[1]), 32'd0);
        chk("r0_p0_c2", 32'(r0_log[2]), 32'd1);
        chk("r0_p0_c3", 32'(r0_log[3]), 32'd0);
        chk("r0_p1_c0", 32'(r0_log[4]), 32'd0);
        chk("r0_p1_c1", 32'(r0_log[5]), 32'd1);
        chk("sclk_pulses_p0", 32'(sclk_per[0]), 32'd4);
        chk("sclk_pulses_p1", 32'(sclk_per[1]), 32'd4);
        chk("oe_low_p0", 32'(oe_runs[0]), 32'd3);
        chk("oe_low_p1", 32'(oe_runs[1]), 32'd6);
        chk("oe_low_r1p0", 32'(oe_runs[2]), 32'd3);
        chk("oe_low_r1p1", 32'(oe_runs[3]), 32'd6);
        chk("frame_starts", 32'(fs_count), 32'd2);

        // Drop enable during the shift of row 1 plane 0
        wait_lat(10, 60);
        i = 0;
        while (sclk !== 1'b1 && i < 40) begin step(); i++; end
        chk("wait_sclk_timeout", 32'(sclk), 32'd1);
        #1 enable = 1'b0;
        n0 = oe_runs.size();
        repeat (40) step();
        chk("drop_runs", 32'(oe_runs.size()), 32'(n0 + 1));
        chk("drop_last_run", 32'(oe_runs[n0]), 32'd3);
        chk("drop_lats", 32'(lat_rows.size()), 32'd11);
        chk("drop_lat_row", 32'(lat_rows[10]), 32'd1);
        chk("drop_idle_oe_n", 32'(oe_n), 32'd1);
        chk("drop_no_fs", 32'(fs_count), 32'd2);

        #1 enable = 1'b1;
        wait_lat(12, 60);
        wait_runs(n0 + 2, 40);
        chk("resume_run", 32'(oe_runs[n0 + 1]), 32'd6);
        chk("resume_row", 32'(lat_rows[11]), 32'd1);
        chk("resume_no_fs", 32'(fs_count), 32'd2);
        base = r0_log.size() - 4;
        chk("resume_r0_c0", 32'(r0_log[base]), 32'd0);
        chk("resume_r0_c1", 32'(r0_log[base + 1]), 32'd1);

        // Asynchronous reset in the middle of row 2 plane 0 display
        i = 0;
        while (oe_n !== 1'b0 && i < 40) begin step(); i++; end
        chk("wait_display_timeout", 32'(oe_n), 32'd0);
        chk("pre_rst_row_addr", 32'(row_addr), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_oe_n", 32'(oe_n), 32'd1);
        chk("async_lat", 32'(lat), 32'd0);
        chk("async_sclk", 32'(sclk), 32'd0);
        chk("async_row_addr", 32'(row_addr), 32'd0);
        chk("async_fb_addr", 32'(fb_addr), 32'd0);
        fsb = fs_count;
        repeat (2) step();
        #1 rst_n = 1'b1;
        repeat (20) step();
        chk("restart_fs_once", 32'(fs_count), 32'(fsb + 1));
        chk("restart_fb_addr", 32'(fs_addr), 32'd0);

        // Wide configuration: BPC=4, BASE_CYCLES=8
        chk("w_runs_seen", 32'(w_runs.size() >= 4), 32'd1);
        chk("w_plane0", 32'(w_runs[0]), 32'd8);
        chk("w_plane1", 32'(w_runs[1]), 32'd16);
        chk("w_plane2", 32'(w_runs[2]), 32'd32);
        chk("w_plane3", 32'(w_runs[3]), 32'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
